// File: rtl/layer_serializer.sv
// Captures the parallel posit results a layer presents at end-of-window and
// re-emits them downstream as one sow/eow framed window, one posit per beat.
module layer_serializer #(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_POSITRON = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               rtr_o,
    input  logic                               rts_i,
    input  logic                               eow_i,
    input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posits_i,
    input  logic                               rtr_i,
    output logic                               rts_o,
    output logic                               sow_o,
    output logic                               eow_o,
    output logic [POSIT_WIDTH-1:0]             posit_o
);

    localparam int IDX_W = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRON - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                                   state_q, state_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    logic [NB_POSITRON-1:0][POSIT_WIDTH-1:0]  lane_q, lane_d;
    logic                                     rtr_q, rtr_d;
    logic                                     rts_q, rts_d;
    logic                                     sow_q, sow_d;
    logic                                     eow_q, eow_d;
    logic [POSIT_WIDTH-1:0]                   posit_q, posit_d;

    // Outputs are precomputed for the beat after the edge, so nothing
    // downstream ever sees a combinational path from rtr_i or rts_i.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        rtr_d   = rtr_q;
        rts_d   = rts_q;
        sow_d   = sow_q;
        eow_d   = eow_q;
        posit_d = posit_q;
        case (state_q)
            IDLE: begin
                if (rts_i && eow_i && rtr_q) begin
                    lane_d  = posits_i;
                    idx_d   = '0;
                    state_d = SEND;
                    rtr_d   = 1'b0;
                    rts_d   = 1'b1;
                    sow_d   = 1'b1;
                    eow_d   = (LAST_IDX == '0);
                    posit_d = posits_i[POSIT_WIDTH-1:0];
                end
            end
            SEND: begin
                if (rtr_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        rtr_d   = 1'b1;
                        rts_d   = 1'b0;
                        sow_d   = 1'b0;
                        eow_d   = 1'b0;
                        posit_d = '0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        sow_d   = 1'b0;
                        eow_d   = (idx_d == LAST_IDX);
                        posit_d = lane_q[idx_d];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lane_q  <= '0;
            rtr_q   <= 1'b1;
            rts_q   <= 1'b0;
            sow_q   <= 1'b0;
            eow_q   <= 1'b0;
            posit_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            rtr_q   <= rtr_d;
            rts_q   <= rts_d;
            sow_q   <= sow_d;
            eow_q   <= eow_d;
            posit_q <= posit_d;
        end
    end

    assign rtr_o   = rtr_q;
    assign rts_o   = rts_q;
    assign sow_o   = sow_q;
    assign eow_o   = eow_q;
    assign posit_o = posit_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: a 4-lane and a 1-lane instance checked every cycle
// against a queue-of-pending-beats model of one framed window.
module tb_layer_serializer;

    localparam int W  = 4;
    localparam int NA = 4;
    localparam int NB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_rts_i, a_eow_i, a_rtr_i;
    logic [NA*W-1:0] a_posits_i;
    logic          a_rtr_o, a_rts_o, a_sow_o, a_eow_o;
    logic [W-1:0]  a_posit_o;

    logic          b_rts_i, b_eow_i, b_rtr_i;
    logic [NB*W-1:0] b_posits_i;
    logic          b_rtr_o, b_rts_o, b_sow_o, b_eow_o;
    logic [W-1:0]  b_posit_o;

    layer_serializer #(.POSIT_WIDTH(W), .NB_POSITRON(NA)) dutA (
        .clk(clk), .rst_n(rst_n), .rtr_o(a_rtr_o), .rts_i(a_rts_i), .eow_i(a_eow_i),
        .posits_i(a_posits_i), .rtr_i(a_rtr_i), .rts_o(a_rts_o), .sow_o(a_sow_o),
        .eow_o(a_eow_o), .posit_o(a_posit_o)
    );

    layer_serializer #(.POSIT_WIDTH(W), .NB_POSITRON(NB)) dutB (
        .clk(clk), .rst_n(rst_n), .rtr_o(b_rtr_o), .rts_i(b_rts_i), .eow_i(b_eow_i),
        .posits_i(b_posits_i), .rtr_i(b_rtr_i), .rts_o(b_rts_o), .sow_o(b_sow_o),
        .eow_o(b_eow_o), .posit_o(b_posit_o)
    );

    int checks = 0;
    int fails  = 0;

    // Model: the beats still owed downstream, and how many were already sent.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int posA = 0;
    int posB = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic ea, eb;
        ea = (qa.size() != 0);
        eb = (qb.size() != 0);
        checkOutput("A.rtr_o", 32'(a_rtr_o), 32'(!ea));
        checkOutput("A.rts_o", 32'(a_rts_o), 32'(ea));
        checkOutput("A.sow_o", 32'(a_sow_o), 32'(ea && posA == 0));
        checkOutput("A.eow_o", 32'(a_eow_o), 32'(ea && qa.size() == 1));
        checkOutput("A.posit_o", 32'(a_posit_o), ea ? 32'(qa[0]) : 32'h0);
        checkOutput("B.rtr_o", 32'(b_rtr_o), 32'(!eb));
        checkOutput("B.rts_o", 32'(b_rts_o), 32'(eb));
        checkOutput("B.sow_o", 32'(b_sow_o), 32'(eb && posB == 0));
        checkOutput("B.eow_o", 32'(b_eow_o), 32'(eb && qb.size() == 1));
        checkOutput("B.posit_o", 32'(b_posit_o), eb ? 32'(qb[0]) : 32'h0);
    endtask

    // One clock: model decisions use the inputs as they stand before the edge.
    task automatic applyStimulus();
        bit capA, xferA, capB, xferB;
        capA  = (qa.size() == 0) && a_rts_i && a_eow_i;
        xferA = (qa.size() != 0) && a_rtr_i;
        capB  = (qb.size() == 0) && b_rts_i && b_eow_i;
        xferB = (qb.size() != 0) && b_rtr_i;
        @(posedge clk);
        if (capA) begin
            for (int k = 0; k < NA; k++) qa.push_back(a_posits_i[k*W +: W]);
            posA = 0;
        end else if (xferA) begin
            void'(qa.pop_front());
            posA++;
        end
        if (capB) begin
            for (int k = 0; k < NB; k++) qb.push_back(b_posits_i[k*W +: W]);
            posB = 0;
        end else if (xferB) begin
            void'(qb.pop_front());
            posB++;
        end
        #1;
        checkAll();
    endtask

    initial begin
        rst_n = 1'b0;
        a_rts_i = 0; a_eow_i = 0; a_rtr_i = 1; a_posits_i = '0;
        b_rts_i = 0; b_eow_i = 0; b_rtr_i = 1; b_posits_i = '0;
        #12;
        checkAll();
        rst_n = 1'b1;
        applyStimulus();

        // Basic window on A, single-beat window on B.
        a_posits_i = {4'h4, 4'h3, 4'h2, 4'h1};
        b_posits_i = 4'h5;
        a_rts_i = 1; a_eow_i = 1; b_rts_i = 1; b_eow_i = 1;
        applyStimulus();
        checkOutput("A.first_beat", 32'(a_posit_o), 32'h1);
        checkOutput("B.single_beat", 32'({b_sow_o, b_eow_o, b_posit_o}), 32'h35);
        a_rts_i = 0; a_eow_i = 0; b_rts_i = 0; b_eow_i = 0;
        repeat (5) applyStimulus();

        // Downstream stall while index 2 is on the output.
        a_rts_i = 1; a_eow_i = 1;
        applyStimulus();
        a_rts_i = 0; a_eow_i = 0;
        repeat (2) applyStimulus();
        a_rtr_i = 0;
        repeat (3) applyStimulus();
        checkOutput("A.stall_hold", 32'({a_rts_o, a_eow_o, a_posit_o}), 32'h23);
        a_rtr_i = 1;
        repeat (3) applyStimulus();

        // rts without eow is ignored; NaR and zero pass unchanged.
        a_rts_i = 1; a_eow_i = 0;
        repeat (2) applyStimulus();
        checkOutput("A.no_capture", 32'({a_rtr_o, a_rts_o}), 32'h2);
        a_posits_i = {4'h7, 4'hF, 4'h0, 4'h8};
        a_eow_i = 1;
        applyStimulus();
        a_rts_i = 0; a_eow_i = 0;
        a_posits_i = '0;
        repeat (5) applyStimulus();

        // Upstream keeps offering new data throughout SEND.
        a_rts_i = 1; a_eow_i = 1; b_rts_i = 1; b_eow_i = 1;
        for (int i = 0; i < 12; i++) begin
            a_posits_i = NA*W'($urandom);
            b_posits_i = NB*W'($urandom);
            applyStimulus();
        end
        a_rts_i = 0; a_eow_i = 0; b_rts_i = 0; b_eow_i = 0;
        repeat (5) applyStimulus();

        // Asynchronous reset while beat 2 of 4 is on the output.
        a_posits_i = {4'hD, 4'hC, 4'hB, 4'hA};
        a_rts_i = 1; a_eow_i = 1;
        applyStimulus();
        a_rts_i = 0; a_eow_i = 0;
        applyStimulus();
        rst_n = 1'b0;
        #2;
        qa.delete();
        qb.delete();
        checkOutput("A.reset_rts", 32'(a_rts_o), 32'h0);
        checkOutput("A.reset_rtr", 32'(a_rtr_o), 32'h1);
        checkOutput("A.reset_eow", 32'(a_eow_o), 32'h0);
        #1;
        rst_n = 1'b1;
        a_rts_i = 1; a_eow_i = 1;
        applyStimulus();
        a_rts_i = 0; a_eow_i = 0;
        repeat (5) applyStimulus();

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            a_rts_i    = 1'($urandom_range(0, 1));
            a_eow_i    = 1'($urandom_range(0, 1));
            a_rtr_i    = ($urandom_range(0, 3) != 0);
            a_posits_i = NA*W'($urandom);
            b_rts_i    = 1'($urandom_range(0, 1));
            b_eow_i    = 1'($urandom_range(0, 1));
            b_rtr_i    = ($urandom_range(0, 3) != 0);
            b_posits_i = NB*W'($urandom);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
